// File: rtl/l2_bus_pkg.sv
// Shared definitions for the L2 bus-operation protocol.
// Used by the responder here and by the L2 controller's initiator and snoop logic.
package l2_bus_pkg;

  typedef enum logic [2:0] {
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_INVAL = 3'd3,
    OP_RWIM  = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'b00,
    SNP_HIT   = 2'b01,
    SNP_HITM  = 2'b10
  } snoop_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_WB,
    ST_MEM,
    ST_RESP
  } bus_state_e;

  // The emulated remote caches answer according to the low two address bits.
  function automatic snoop_e snoop_decode(input logic [1:0] addr_lo);
    case (addr_lo)
      2'b00:   return SNP_HIT;
      2'b01:   return SNP_HITM;
      default: return SNP_NOHIT;
    endcase
  endfunction

endpackage

// File: rtl/l2_sat_counter.sv
// Saturating up-counter for bus statistics.
// It holds at all-ones instead of wrapping; clear is synchronous.
module l2_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l2_bus_responder.sv
// Bus-side responder for L2 bus operations: snoop result, remote HITM writeback,
// memory latency and one completion per accepted request.
module l2_bus_responder
  import l2_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int SNOOP_LAT = 2,
  parameter int WB_LAT    = 3,
  parameter int MEM_LAT   = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [1:0]        rsp_snoop,
  output logic              rsp_wb,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  cnt_read,
  output logic [CNT_W-1:0]  cnt_write,
  output logic [CNT_W-1:0]  cnt_inval,
  output logic [CNT_W-1:0]  cnt_rwim,
  output logic [CNT_W-1:0]  cnt_hitm
);

  localparam int TMR_W = 16;

  bus_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       op_q;
  snoop_e           snp_q;
  logic             wb_q;
  logic             accept;
  logic             unused_addr;

  // Only the low address bits select the snoop answer.
  assign unused_addr = ^req_addr[ADDR_W-1:2];

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      op_q    <= '0;
      snp_q   <= SNP_NOHIT;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (accept) begin
        op_q  <= req_op;
        snp_q <= snoop_decode(req_addr[1:0]);
        wb_q  <= 1'b0;
      end else if (state_q == ST_WB) begin
        wb_q <= 1'b1;
      end
    end
  end

  // An illegal op enters RESP with the timer at 1 so its completion still
  // lands one edge after acceptance; every other path enters RESP at 0.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rsp_valid = 1'b0;
    rsp_snoop = SNP_NOHIT;
    rsp_wb    = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_READ, OP_RWIM, OP_INVAL: begin
              state_d = ST_SNOOP;
              timer_d = TMR_W'(SNOOP_LAT - 1);
            end
            OP_WRITE: begin
              state_d = ST_MEM;
              timer_d = TMR_W'(MEM_LAT - 1);
            end
            default: begin
              state_d = ST_RESP;
              timer_d = TMR_W'(1);
            end
          endcase
        end
      end
      ST_SNOOP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (op_q == OP_INVAL) begin
          state_d = ST_RESP;
          timer_d = '0;
        end else if (snp_q == SNP_HITM) begin
          state_d = ST_WB;
          timer_d = TMR_W'(WB_LAT - 1);
        end else begin
          state_d = ST_MEM;
          timer_d = TMR_W'(MEM_LAT - 1);
        end
      end
      ST_WB: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = ST_MEM;
          timer_d = TMR_W'(MEM_LAT - 1);
        end
      end
      ST_MEM: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = ST_RESP;
          timer_d = '0;
        end
      end
      ST_RESP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d   = ST_IDLE;
          rsp_valid = 1'b1;
          rsp_wb    = wb_q;
          case (op_q)
            OP_READ, OP_RWIM: rsp_snoop = snp_q;
            OP_WRITE:         rsp_snoop = SNP_NOHIT;
            OP_INVAL: begin
              // A modified copy elsewhere contradicts our shared line.
              if (snp_q == SNP_HITM) begin
                rsp_snoop = SNP_HIT;
                rsp_err   = 1'b1;
              end else begin
                rsp_snoop = snp_q;
              end
            end
            default:          rsp_err = 1'b1;
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  logic inc_read, inc_write, inc_inval, inc_rwim, inc_hitm;

  assign inc_read  = rsp_valid && (op_q == OP_READ);
  assign inc_write = rsp_valid && (op_q == OP_WRITE);
  assign inc_inval = rsp_valid && (op_q == OP_INVAL);
  assign inc_rwim  = rsp_valid && (op_q == OP_RWIM);
  assign inc_hitm  = rsp_valid && ((op_q == OP_READ) || (op_q == OP_RWIM))
                     && (snp_q == SNP_HITM);

  l2_sat_counter #(.CNT_W(CNT_W)) u_cnt_read (
    .clk(clk), .clear(rst), .inc(inc_read), .count(cnt_read)
  );
  l2_sat_counter #(.CNT_W(CNT_W)) u_cnt_write (
    .clk(clk), .clear(rst), .inc(inc_write), .count(cnt_write)
  );
  l2_sat_counter #(.CNT_W(CNT_W)) u_cnt_inval (
    .clk(clk), .clear(rst), .inc(inc_inval), .count(cnt_inval)
  );
  l2_sat_counter #(.CNT_W(CNT_W)) u_cnt_rwim (
    .clk(clk), .clear(rst), .inc(inc_rwim), .count(cnt_rwim)
  );
  l2_sat_counter #(.CNT_W(CNT_W)) u_cnt_hitm (
    .clk(clk), .clear(rst), .inc(inc_hitm), .count(cnt_hitm)
  );

endmodule

// File: tb/tb_l2_bus_responder.sv
// Bench for l2_bus_responder: directed table, back-to-back, reset-abort and
// saturation sequences, then random operations against a rule-based model.
module tb_l2_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;

  logic        req_ready, rsp_valid, rsp_wb, rsp_err;
  logic [1:0]  rsp_snoop;
  logic [15:0] cnt_read, cnt_write, cnt_inval, cnt_rwim, cnt_hitm;

  logic        s_ready, s_valid, s_wb, s_err;
  logic [1:0]  s_snoop;
  logic [1:0]  s_read, s_write, s_inval, s_rwim, s_hitm;

  l2_bus_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .rsp_valid(rsp_valid),
    .rsp_snoop(rsp_snoop), .rsp_wb(rsp_wb), .rsp_err(rsp_err),
    .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_inval(cnt_inval),
    .cnt_rwim(cnt_rwim), .cnt_hitm(cnt_hitm)
  );

  l2_bus_responder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_ready),
    .req_op(req_op), .req_addr(req_addr), .rsp_valid(s_valid),
    .rsp_snoop(s_snoop), .rsp_wb(s_wb), .rsp_err(s_err),
    .cnt_read(s_read), .cnt_write(s_write), .cnt_inval(s_inval),
    .cnt_rwim(s_rwim), .cnt_hitm(s_hitm)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int mRead, mWrite, mInval, mRwim, mHitm;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    int          lat;
    int          snoop;
    int          wb;
    int          err;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic bit isHitm(input logic [31:0] a);
    return a[1:0] == 2'b01;
  endfunction

  // Reference rules: latency is the sum of the phases the operation visits.
  function automatic int modelLat(input logic [2:0] op, input logic [31:0] a);
    case (op)
      3'd1, 3'd4: return 2 + 4 + (isHitm(a) ? 3 : 0);
      3'd2:       return 4;
      3'd3:       return 2;
      default:    return 1;
    endcase
  endfunction

  function automatic int modelSnoop(input logic [2:0] op, input logic [31:0] a);
    int raw;
    raw = (a[1:0] == 2'b00) ? 1 : (a[1:0] == 2'b01) ? 2 : 0;
    case (op)
      3'd1, 3'd4: return raw;
      3'd3:       return (raw == 2) ? 1 : raw;
      default:    return 0;
    endcase
  endfunction

  function automatic int modelErr(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd0 || op > 3'd4) return 1;
    return (op == 3'd3 && isHitm(a)) ? 1 : 0;
  endfunction

  function automatic int modelWb(input logic [2:0] op, input logic [31:0] a);
    return ((op == 3'd1 || op == 3'd4) && isHitm(a)) ? 1 : 0;
  endfunction

  task automatic modelCount(input logic [2:0] op, input logic [31:0] a);
    case (op)
      3'd1: mRead++;
      3'd2: mWrite++;
      3'd3: mInval++;
      3'd4: mRwim++;
      default: ;
    endcase
    if ((op == 3'd1 || op == 3'd4) && isHitm(a)) mHitm++;
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, ".cnt_read"},  cnt_read,  sat(mRead, 65535));
    checkOutput({name, ".cnt_write"}, cnt_write, sat(mWrite, 65535));
    checkOutput({name, ".cnt_inval"}, cnt_inval, sat(mInval, 65535));
    checkOutput({name, ".cnt_rwim"},  cnt_rwim,  sat(mRwim, 65535));
    checkOutput({name, ".cnt_hitm"},  cnt_hitm,  sat(mHitm, 65535));
    checkOutput({name, ".sat_read"},  s_read,    sat(mRead, 3));
    checkOutput({name, ".sat_hitm"},  s_hitm,    sat(mHitm, 3));
  endtask

  // Issues one request and measures edges from acceptance to completion.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               output int lat, output int snp, output int wb,
                               output int err, output int busyOk);
    int w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    if (!req_ready) checkOutput("ready_wait", 0, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    lat = -1; snp = 0; wb = 0; err = 0; busyOk = 1;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) tick();
      if (req_ready) busyOk = 0;
      if (rsp_valid) begin
        lat = n; snp = rsp_snoop; wb = rsp_wb; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic runTxn(input string name, input logic [2:0] op, input logic [31:0] a,
                        input int eLat, input int eSnp, input int eWb, input int eErr);
    int lat, snp, wb, err, busyOk;
    applyStimulus(op, a, lat, snp, wb, err, busyOk);
    checkOutput({name, ".lat"},   lat, eLat);
    checkOutput({name, ".snoop"}, snp, eSnp);
    checkOutput({name, ".wb"},    wb,  eWb);
    checkOutput({name, ".err"},   err, eErr);
    checkOutput({name, ".busy"},  busyOk, 1);
    modelCount(op, a);
    tick();
    checkOutput({name, ".rsp_idle"}, {rsp_valid, rsp_snoop, rsp_wb, rsp_err}, 0);
    checkCounters(name);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, seen;
    logic [2:0]  rop;
    logic [31:0] raddr;

    vecs[0] = '{op: 3'd1, addr: 32'h0000_1000, lat: 6, snoop: 1, wb: 0, err: 0};
    vecs[1] = '{op: 3'd4, addr: 32'h0000_2001, lat: 9, snoop: 2, wb: 1, err: 0};
    vecs[2] = '{op: 3'd3, addr: 32'h0000_0005, lat: 2, snoop: 1, wb: 0, err: 1};
    vecs[3] = '{op: 3'd7, addr: 32'h0000_0000, lat: 1, snoop: 0, wb: 0, err: 1};
    vecs[4] = '{op: 3'd0, addr: 32'h0000_0001, lat: 1, snoop: 0, wb: 0, err: 1};

    mRead = 0; mWrite = 0; mInval = 0; mRwim = 0; mHitm = 0;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0;
    repeat (3) tick();
    checkOutput("reset.ready", req_ready, 1);
    checkOutput("reset.rsp", {rsp_valid, rsp_snoop, rsp_wb, rsp_err}, 0);
    checkCounters("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      runTxn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr,
             vecs[i].lat, vecs[i].snoop, vecs[i].wb, vecs[i].err);

    // WRITE then INVALIDATE with req_valid held high the whole time.
    req_valid = 1'b1; req_op = 3'd2; req_addr = 32'h0000_3003;
    tick();
    req_op = 3'd3; req_addr = 32'h0000_4002;
    n = -1; seen = 0;
    for (int k = 1; k <= 20; k++) begin
      if (req_ready) seen = 1;
      if (rsp_valid) begin n = k - 1; break; end
      tick();
    end
    checkOutput("b2b.write_lat", n, 4);
    checkOutput("b2b.write_snoop", rsp_snoop, 0);
    checkOutput("b2b.busy_ready", seen, 0);
    mWrite++;
    tick();
    checkOutput("b2b.ready_idle", req_ready, 1);
    checkOutput("b2b.gap_rsp", rsp_valid, 0);
    tick();
    checkOutput("b2b.inval_taken", req_ready, 0);
    tick();
    checkOutput("b2b.inval_early", rsp_valid, 0);
    tick();
    checkOutput("b2b.inval_rsp", rsp_valid, 1);
    checkOutput("b2b.inval_snoop", rsp_snoop, 0);
    checkOutput("b2b.inval_err", rsp_err, 0);
    req_valid = 1'b0;
    mInval++;
    tick();
    checkCounters("b2b");

    // Reset lands in the WB phase of a HITM READ.
    req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h0000_6001;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mRead = 0; mWrite = 0; mInval = 0; mRwim = 0; mHitm = 0;
    checkOutput("rst.ready", req_ready, 1);
    checkOutput("rst.rsp", rsp_valid, 0);
    checkCounters("rst");
    seen = 0;
    repeat (12) begin
      tick();
      if (rsp_valid) seen = 1;
    end
    checkOutput("rst.no_rsp", seen, 0);

    for (int i = 0; i < 5; i++)
      runTxn($sformatf("satrd%0d", i), 3'd1, 32'h0000_1000, 6, 1, 0, 0);
    checkOutput("sat.read_w2", s_read, 3);
    checkOutput("sat.read_w16", cnt_read, 5);

    for (int i = 0; i < 30; i++) begin
      rop   = 3'($urandom_range(0, 7));
      raddr = $urandom;
      runTxn($sformatf("rnd%0d", i), rop, raddr, modelLat(rop, raddr),
             modelSnoop(rop, raddr), modelWb(rop, raddr), modelErr(rop, raddr));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/l2_bus_responder.md
Name: l2_bus_responder

Overview:
- Models the shared-bus side that answers the L2 cache's outgoing bus operations: READ, WRITE, INVALIDATE and RWIM.
- For each operation it produces the other caches' snoop result (HIT/HITM/NOHIT), emulates the remote writeback when the result is HITM, and applies memory latency.
- It returns one completion per request.
- It sits between the L2 controller (the initiator) and the bus/memory model, and is the responder end of the L2 bus-operation protocol.

Parameters:
- ADDR_W, 32, address width (matches add_size).
- SNOOP_LAT, 2, cycles spent in the snoop phase (>=1).
- WB_LAT, 3, cycles for the remote HITM writeback (>=1).
- MEM_LAT, 4, cycles for the memory access (>=1).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  bus operation request.
- req_ready  out  1  responder can accept a request.
- req_op  in  3  1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM; other values are illegal.
- req_addr  in  ADDR_W  bus address.
- rsp_valid  out  1  completion pulse, exactly 1 cycle.
- rsp_snoop  out  2  00=NOHIT, 01=HIT, 10=HITM.
- rsp_wb  out  1  a remote writeback preceded this completion.
- rsp_err  out  1  illegal op or protocol violation.
- cnt_read, cnt_write, cnt_inval, cnt_rwim, cnt_hitm  out  CNT_W each  saturating statistics counters.

Behaviour:
- Interface decision: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_snoop=00, rsp_wb=0, rsp_err=0.
  - All counters 0, timer 0.
  - Reset in any state aborts the operation with no response; reset dominates every other event.
- Acceptance: on an edge with req_valid&&req_ready the responder captures op and addr. req_ready=1 only in IDLE, so there is at most one outstanding request. req_op and req_addr are ignored when req_ready=0.
- Snoop result decode, from captured addr[1:0]:
  - 00 -> HIT.
  - 01 -> HITM.
  - 1x -> NOHIT.
- States: IDLE, SNOOP, WB, MEM, RESP. A timer loads on each state entry and counts down.
- Per-operation paths:
  - READ, RWIM: IDLE -> SNOOP (SNOOP_LAT) -> [WB (WB_LAT) if HITM] -> MEM (MEM_LAT) -> RESP.
  - WRITE: IDLE -> MEM (MEM_LAT) -> RESP. No snoop; rsp_snoop=NOHIT.
  - INVALIDATE: IDLE -> SNOOP (SNOOP_LAT) -> RESP. If the decode gives HITM (another cache modified a line we hold shared), set rsp_err=1 and report rsp_snoop=HIT. No WB phase.
  - Illegal op: IDLE -> RESP. rsp_err=1, rsp_snoop=NOHIT, no counter changes.
- Latency: rsp_valid is high in the cycle after the N-th edge following the acceptance edge.
  - READ/RWIM: N = SNOOP_LAT+MEM_LAT, +WB_LAT if HITM.
  - WRITE: N = MEM_LAT.
  - INVALIDATE: N = SNOOP_LAT.
  - Illegal op: N = 1.
  - Defaults: 6, 9 (HITM), 4, 2, 1.
- RESP lasts 1 cycle with no backpressure. rsp_* fields are valid only while rsp_valid=1 and return to 0 afterwards.
- RESP -> IDLE; req_ready rises the cycle after RESP. A new request can be accepted on the first IDLE edge, which gives a minimum gap of 1 idle cycle between completion and the next acceptance.
- rsp_wb=1 exactly when the WB phase was traversed.
- Counters:
  - Update on the RESP cycle edge, and saturate at all-ones.
  - cnt_read, cnt_write, cnt_inval or cnt_rwim increments for the matching legal op.
  - cnt_hitm increments when READ/RWIM has a HITM result. An INVALIDATE protocol error does not count.

Decomposition:
- Shared package l2_bus_pkg holds:
  - bus op codes (READ..RWIM);
  - snoop result codes (NOHIT/HIT/HITM);
  - the FSM state enum;
  - the snoop decode function.
- The same package is reused by the L2 controller's initiator side and its put-snoop logic.
- One sub-module, l2_sat_counter (CNT_W, inc, clear), instantiated 5 times.

Test Plan:
1. Reset, then READ addr 0x0000_1000 -> rsp_valid 6 cycles after accept, snoop=HIT, wb=0, cnt_read=1.
2. RWIM addr 0x0000_2001 -> rsp_valid after 9 cycles, snoop=HITM, wb=1, cnt_rwim=1, cnt_hitm=1.
3. WRITE 0x0000_3003, then INVALIDATE 0x0000_4002 back-to-back, with req_valid held high throughout:
   - WRITE completes after 4 cycles with NOHIT.
   - req_ready is 0 while busy.
   - INVALIDATE is accepted 1 cycle after the WRITE RESP and completes 2 cycles later with NOHIT.
4. INVALIDATE addr 0x5 -> snoop=HIT, err=1, cnt_inval=1, cnt_hitm unchanged. Then op=7 -> completion after 1 cycle, err=1, no counter changes.
5. Assert rst during the WB phase of a HITM READ -> no rsp_valid, req_ready=1 on the next cycle, all counters 0.
6. Run with CNT_W=2 and 5 READs -> cnt_read saturates at 3.
